// File: rtl/amo_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : amo_memory_responder
//  Description : Memory-side responder for RV32A atomics. Accepts one
//                AMO/LR/SC request at a time, performs the read-modify-write
//                on a single-port memory and returns the original word.
//                Holds a single LR/SC reservation that external store snoops,
//                own AMO writes, SC, a new LR or reset can clear.
//  Ports       : clk, rst (sync, active-high)
//                req_*_i / req_ready_o     : core-side request channel
//                mem_*_o / mem_*_i         : single-port memory command/read
//                snoop_valid_i/addr_i      : store snoop from other masters
//                rsp_*_o / rsp_ready_i     : response channel (held until ready)
//  Config      : define AMO_RESP_RES_TIMEOUT_EN to let the reservation expire
//                RES_TIMEOUT cycles after the LR that set it.
//  Revision    : 1.0 - initial release
// ============================================================================
module amo_memory_responder #(
    parameter int ID_W        = 4,
    parameter int RES_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [4:0]      req_fn5_i,
    input  logic [31:0]     req_addr_i,
    input  logic [31:0]     req_wdata_i,
    input  logic [ID_W-1:0] req_id_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic            mem_we_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i,
    input  logic            snoop_valid_i,
    input  logic [31:0]     snoop_addr_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_data_o,
    output logic [ID_W-1:0] rsp_id_o,
    output logic            rsp_err_o
);

    // RV32A funct5 encodings
    localparam logic [4:0] c_FN_ADD  = 5'b00000;
    localparam logic [4:0] c_FN_SWAP = 5'b00001;
    localparam logic [4:0] c_FN_LR   = 5'b00010;
    localparam logic [4:0] c_FN_SC   = 5'b00011;
    localparam logic [4:0] c_FN_XOR  = 5'b00100;
    localparam logic [4:0] c_FN_OR   = 5'b01000;
    localparam logic [4:0] c_FN_AND  = 5'b01100;
    localparam logic [4:0] c_FN_MIN  = 5'b10000;
    localparam logic [4:0] c_FN_MAX  = 5'b10100;
    localparam logic [4:0] c_FN_MINU = 5'b11000;
    localparam logic [4:0] c_FN_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t          state_q;
    logic [4:0]      fn5_q;
    logic [29:0]     waddr_q;
    logic [31:0]     rs2_q;
    logic [ID_W-1:0] id_q;
    logic            lr_snooped_q;   // matching snoop seen while an LR is reading
    logic            res_valid_q;
    logic [29:0]     res_addr_q;

    logic            req_ready_q;
    logic            mem_req_valid_q;
    logic            mem_we_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            rsp_err_q;

    logic            w_accept;
    logic            w_res_live;
    logic            w_snoop_hit_res;
    logic            w_snoop_hit_cur;
    logic            w_sc_ok;
    logic            w_supported;
    logic [31:0]     w_new_word;

    // Only word addresses are compared or issued
    logic            w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{req_addr_i[1:0], snoop_addr_i[1:0]};

    function automatic logic [31:0] amo_alu(input logic [31:0] old_w,
                                            input logic [31:0] rs2,
                                            input logic [4:0]  fn);
        logic [31:0] res;
        res = old_w;
        case (fn)
            c_FN_SWAP: res = rs2;
            c_FN_ADD:  res = old_w + rs2;
            c_FN_XOR:  res = old_w ^ rs2;
            c_FN_AND:  res = old_w & rs2;
            c_FN_OR:   res = old_w | rs2;
            // Strict compares so that equal operands keep the old word
            c_FN_MIN:  res = ($signed(rs2) < $signed(old_w)) ? rs2 : old_w;
            c_FN_MAX:  res = ($signed(rs2) > $signed(old_w)) ? rs2 : old_w;
            c_FN_MINU: res = (rs2 < old_w) ? rs2 : old_w;
            c_FN_MAXU: res = (rs2 > old_w) ? rs2 : old_w;
            default:   res = old_w;
        endcase
        return res;
    endfunction

`ifdef AMO_RESP_RES_TIMEOUT_EN
    localparam int c_CNT_W = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT + 1) : 1;
    logic [c_CNT_W-1:0] res_cnt_q;
    // A counter sitting at zero is the expiry cycle: the reservation is
    // already treated as gone so an SC accepted now fails.
    assign w_res_live = res_valid_q && (res_cnt_q != '0);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (RES_TIMEOUT != 0);
    assign w_res_live       = res_valid_q;
`endif

    assign w_accept        = req_valid_i && req_ready_q;
    assign w_snoop_hit_res = snoop_valid_i && res_valid_q && (snoop_addr_i[31:2] == res_addr_q);
    assign w_snoop_hit_cur = snoop_valid_i && (snoop_addr_i[31:2] == waddr_q);
    // A snoop to the same word in the SC accept cycle beats the SC
    assign w_sc_ok         = w_res_live && (res_addr_q == req_addr_i[31:2]) &&
                             !(snoop_valid_i && (snoop_addr_i[31:2] == req_addr_i[31:2]));
    assign w_supported     = (fn5_q == c_FN_SWAP) || (fn5_q == c_FN_ADD)  || (fn5_q == c_FN_XOR) ||
                             (fn5_q == c_FN_AND)  || (fn5_q == c_FN_OR)   || (fn5_q == c_FN_MIN) ||
                             (fn5_q == c_FN_MAX)  || (fn5_q == c_FN_MINU) || (fn5_q == c_FN_MAXU);
    assign w_new_word      = amo_alu(mem_rdata_i, rs2_q, fn5_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            fn5_q           <= '0;
            waddr_q         <= '0;
            rs2_q           <= '0;
            id_q            <= '0;
            lr_snooped_q    <= 1'b0;
            res_valid_q     <= 1'b0;
            res_addr_q      <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_id_q        <= '0;
            rsp_err_q       <= 1'b0;
`ifdef AMO_RESP_RES_TIMEOUT_EN
            res_cnt_q       <= '0;
`endif
        end else begin
            // Background reservation maintenance; state-specific updates
            // below are later in the block and take precedence.
            if (w_snoop_hit_res) begin
                res_valid_q <= 1'b0;
            end
`ifdef AMO_RESP_RES_TIMEOUT_EN
            if (res_valid_q) begin
                if (res_cnt_q == '0) begin
                    res_valid_q <= 1'b0;
                end else begin
                    res_cnt_q <= res_cnt_q - c_CNT_W'(1);
                end
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        fn5_q        <= req_fn5_i;
                        waddr_q      <= req_addr_i[31:2];
                        rs2_q        <= req_wdata_i;
                        id_q         <= req_id_i;
                        lr_snooped_q <= 1'b0;
                        req_ready_q  <= 1'b0;
                        mem_addr_q   <= {req_addr_i[31:2], 2'b00};
                        if (req_fn5_i == c_FN_SC) begin
                            // SC never reads; it either writes rs2 or fails at once
                            res_valid_q <= 1'b0;
                            rsp_id_q    <= req_id_i;
                            rsp_err_q   <= 1'b0;
                            if (w_sc_ok) begin
                                rsp_data_q      <= 32'd0;
                                mem_req_valid_q <= 1'b1;
                                mem_we_q        <= 1'b1;
                                mem_wdata_q     <= req_wdata_i;
                                state_q         <= S_WR_REQ;
                            end else begin
                                rsp_data_q  <= 32'd1;
                                rsp_valid_q <= 1'b1;
                                state_q     <= S_RESP;
                            end
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= 1'b0;
                            state_q         <= S_RD_REQ;
                        end
                    end
                end

                S_RD_REQ: begin
                    if (w_snoop_hit_cur) begin
                        lr_snooped_q <= 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (w_snoop_hit_cur) begin
                        lr_snooped_q <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        rsp_data_q <= mem_rdata_i;
                        rsp_id_q   <= id_q;
                        if (fn5_q == c_FN_LR) begin
                            // LR replaces any older reservation unless the word
                            // was stored to while the read was in flight
                            if (!lr_snooped_q && !w_snoop_hit_cur) begin
                                res_valid_q <= 1'b1;
                                res_addr_q  <= waddr_q;
`ifdef AMO_RESP_RES_TIMEOUT_EN
                                res_cnt_q   <= c_CNT_W'(RES_TIMEOUT);
`endif
                            end
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else if (w_supported) begin
                            if (res_valid_q && (res_addr_q == waddr_q)) begin
                                res_valid_q <= 1'b0;
                            end
                            rsp_err_q       <= 1'b0;
                            mem_req_valid_q <= 1'b1;
                            mem_we_q        <= 1'b1;
                            mem_wdata_q     <= w_new_word;
                            state_q         <= S_WR_REQ;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end

                S_WR_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        mem_we_q        <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q         <= S_IDLE;
                    req_ready_q     <= 1'b1;
                    mem_req_valid_q <= 1'b0;
                    rsp_valid_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o     = req_ready_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_id_o        = rsp_id_q;
    assign rsp_err_o       = rsp_err_q;

endmodule
`default_nettype wire
